// File: rtl/mips_pkg.sv
// mips_pkg
// Shared constants for the register file slice: default data and address
// widths, the index of the hard-wired zero register, and the largest number of
// read ports the register file supports.
package mips_pkg;

    localparam int DATA_W_DEF   = 32;
    localparam int ADDR_W_DEF   = 5;
    localparam int ZERO_REG_IDX = 0;
    localparam int NUM_RD_MAX   = 4;

endpackage

// File: rtl/rf_scoreboard.sv
// rf_scoreboard
// Tracks which registers are waiting on an outstanding load. A register becomes
// pending when a load issues (sb_set) and is cleared when the load result is
// written back on wr1. Also keeps a running count of pending registers and
// produces a per-read-port busy flag.
//
// Ports:
//   clk, reset   - clock, asynchronous active-high reset
//   sb_set_en    - mark sb_set_addr pending at the next edge
//   sb_set_addr  - register being targeted by an issuing load
//   wr1_en       - load write-back valid; clears the pending bit of wr1_addr
//   wr1_addr     - load write-back destination
//   rd_addr      - packed read addresses, port i at [i*ADDR_W +: ADDR_W]
//   rd_busy      - port i's register is pending and not being forwarded now
//   pend_cnt     - number of registers currently pending
module rf_scoreboard
    import mips_pkg::*;
#(
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int NUM_RD   = 2,
    parameter int ZERO_REG = 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     sb_set_en,
    input  logic [ADDR_W-1:0]        sb_set_addr,
    input  logic                     wr1_en,
    input  logic [ADDR_W-1:0]        wr1_addr,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic [NUM_RD-1:0]        rd_busy,
    output logic [ADDR_W:0]          pend_cnt
);

    localparam int NREGS = 1 << ADDR_W;
    localparam bit ZR    = (ZERO_REG != 0);

    logic [NREGS-1:0]  pending;
    logic [NREGS-1:0]  pending_next;
    logic              set_ok;
    logic              clr_ok;
    logic              net_set;
    logic              net_clr;
    logic [ADDR_W:0]   cnt_next;
    logic [ADDR_W-1:0] port_addr;

    // Next pending state. Set is applied after clear so a load issuing to a
    // register in the same cycle its previous load returns stays pending.
    // The counter only moves when a bit actually changes, which keeps it equal
    // to the population count of the pending vector without ever wrapping.
    always_comb begin
        set_ok       = sb_set_en && !(ZR && sb_set_addr == ADDR_W'(ZERO_REG_IDX));
        clr_ok       = wr1_en    && !(ZR && wr1_addr    == ADDR_W'(ZERO_REG_IDX));
        pending_next = pending;
        if (clr_ok) begin
            pending_next[wr1_addr] = 1'b0;
        end
        if (set_ok) begin
            pending_next[sb_set_addr] = 1'b1;
        end
        net_set  = set_ok && !pending[sb_set_addr];
        net_clr  = clr_ok && pending[wr1_addr] && !(set_ok && sb_set_addr == wr1_addr);
        cnt_next = pend_cnt;
        case ({net_set, net_clr})
            2'b10:   cnt_next = pend_cnt + (ADDR_W+1)'(1);
            2'b01:   cnt_next = pend_cnt - (ADDR_W+1)'(1);
            default: cnt_next = pend_cnt;
        endcase
    end

    // Pending bits and counter share one register stage so they always agree.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pending  <= '0;
            pend_cnt <= '0;
        end else begin
            pending  <= pending_next;
            pend_cnt <= cnt_next;
        end
    end

    // A pending register is not busy when its load result is arriving this
    // cycle, since the top level forwards wr1 data straight to the read port.
    always_comb begin
        rd_busy   = '0;
        port_addr = '0;
        for (int i = 0; i < NUM_RD; i++) begin
            port_addr  = rd_addr[i*ADDR_W +: ADDR_W];
            rd_busy[i] = !reset && pending[port_addr] &&
                         !(wr1_en && wr1_addr == port_addr);
        end
    end

endmodule

// File: rtl/multiport_regfile.sv
// multiport_regfile
// Register file with NUM_RD combinational read ports, two write ports (ALU
// write-back wr0 and load write-back wr1) and a load scoreboard. Reads forward
// same-cycle write data, with wr1 taking priority over wr0. With ZERO_REG set,
// register 0 is hard-wired to zero.
//
// Ports:
//   clk, reset                    - clock, asynchronous active-high reset
//   rd_addr / rd_data / rd_busy   - packed read ports (port i at slice i)
//   wr0_en / wr0_addr / wr0_data  - ALU write-back port
//   wr1_en / wr1_addr / wr1_data  - load write-back port, clears pending
//   sb_set_en / sb_set_addr       - marks a register pending on load issue
//   pend_cnt                      - number of pending registers
module multiport_regfile
    import mips_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int NUM_RD   = 2,
    parameter int ZERO_REG = 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    output logic [NUM_RD-1:0]        rd_busy,
    input  logic                     wr0_en,
    input  logic [ADDR_W-1:0]        wr0_addr,
    input  logic [DATA_W-1:0]        wr0_data,
    input  logic                     wr1_en,
    input  logic [ADDR_W-1:0]        wr1_addr,
    input  logic [DATA_W-1:0]        wr1_data,
    input  logic                     sb_set_en,
    input  logic [ADDR_W-1:0]        sb_set_addr,
    output logic [ADDR_W:0]          pend_cnt
);

    localparam int NREGS = 1 << ADDR_W;
    localparam bit ZR    = (ZERO_REG != 0);

    logic [DATA_W-1:0] mem [NREGS];
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_data;

    // Storage. wr1 is checked first so it wins when both ports hit the same
    // register. The zero register is skipped entirely and keeps its reset 0.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int r = 0; r < NREGS; r++) begin
                mem[r] <= '0;
            end
        end else begin
            for (int r = 0; r < NREGS; r++) begin
                if (!(ZR && r == ZERO_REG_IDX)) begin
                    if (wr1_en && wr1_addr == ADDR_W'(r)) begin
                        mem[r] <= wr1_data;
                    end else if (wr0_en && wr0_addr == ADDR_W'(r)) begin
                        mem[r] <= wr0_data;
                    end
                end
            end
        end
    end

    // Read ports with same-cycle forwarding. Output is forced to zero while
    // reset is held so in-flight write data cannot leak through the bypass.
    always_comb begin
        rd_data  = '0;
        sel_addr = '0;
        sel_data = '0;
        for (int i = 0; i < NUM_RD; i++) begin
            sel_addr = rd_addr[i*ADDR_W +: ADDR_W];
            if (reset) begin
                sel_data = '0;
            end else if (ZR && sel_addr == ADDR_W'(ZERO_REG_IDX)) begin
                sel_data = '0;
            end else if (wr1_en && wr1_addr == sel_addr) begin
                sel_data = wr1_data;
            end else if (wr0_en && wr0_addr == sel_addr) begin
                sel_data = wr0_data;
            end else begin
                sel_data = mem[sel_addr];
            end
            rd_data[i*DATA_W +: DATA_W] = sel_data;
        end
    end

    rf_scoreboard #(
        .ADDR_W   (ADDR_W),
        .NUM_RD   (NUM_RD),
        .ZERO_REG (ZERO_REG)
    ) u_scoreboard (
        .clk         (clk),
        .reset       (reset),
        .sb_set_en   (sb_set_en),
        .sb_set_addr (sb_set_addr),
        .wr1_en      (wr1_en),
        .wr1_addr    (wr1_addr),
        .rd_addr     (rd_addr),
        .rd_busy     (rd_busy),
        .pend_cnt    (pend_cnt)
    );

endmodule

// File: tb/tb_multiport_regfile.sv
// tb_multiport_regfile
// Directed bench for multiport_regfile with default parameters (32-bit data,
// 32 registers, 2 read ports, zero register enabled). A table of per-cycle
// vectors covers writes, forwarding, the zero register and the scoreboard;
// hand-written sequences cover reset behaviour and a full scoreboard.
module tb_multiport_regfile;

    logic        clk;
    logic        reset;
    logic [9:0]  rd_addr;
    logic [63:0] rd_data;
    logic [1:0]  rd_busy;
    logic        wr0_en;
    logic [4:0]  wr0_addr;
    logic [31:0] wr0_data;
    logic        wr1_en;
    logic [4:0]  wr1_addr;
    logic [31:0] wr1_data;
    logic        sb_set_en;
    logic [4:0]  sb_set_addr;
    logic [5:0]  pend_cnt;

    int checks;
    int failures;

    typedef struct {
        logic        wr0_en;
        logic [4:0]  wr0_addr;
        logic [31:0] wr0_data;
        logic        wr1_en;
        logic [4:0]  wr1_addr;
        logic [31:0] wr1_data;
        logic        sb_en;
        logic [4:0]  sb_addr;
        logic [4:0]  ra0;
        logic [4:0]  ra1;
        logic [31:0] exp_d0;
        logic [31:0] exp_d1;
        logic [1:0]  exp_busy;
        logic [5:0]  exp_cnt;
    } vec_t;

    localparam int NVEC = 20;
    vec_t vecs [NVEC];

    multiport_regfile dut (
        .clk         (clk),
        .reset       (reset),
        .rd_addr     (rd_addr),
        .rd_data     (rd_data),
        .rd_busy     (rd_busy),
        .wr0_en      (wr0_en),
        .wr0_addr    (wr0_addr),
        .wr0_data    (wr0_data),
        .wr1_en      (wr1_en),
        .wr1_addr    (wr1_addr),
        .wr1_data    (wr1_data),
        .sb_set_en   (sb_set_en),
        .sb_set_addr (sb_set_addr),
        .pend_cnt    (pend_cnt)
    );

    // Free-running clock, rising edges at 5, 15, 25, ...
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Compare one value and report a mismatch with both values.
    task automatic check_output(input string name, input logic [31:0] actual,
                                input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%h required=%h", name, actual, expected);
        end
    endtask

    // Drive all DUT inputs for one cycle.
    task automatic apply_stimulus(input vec_t v);
        wr0_en      = v.wr0_en;
        wr0_addr    = v.wr0_addr;
        wr0_data    = v.wr0_data;
        wr1_en      = v.wr1_en;
        wr1_addr    = v.wr1_addr;
        wr1_data    = v.wr1_data;
        sb_set_en   = v.sb_en;
        sb_set_addr = v.sb_addr;
        rd_addr     = {v.ra1, v.ra0};
    endtask

    task automatic set_idle();
        wr0_en      = 1'b0;
        wr0_addr    = 5'd0;
        wr0_data    = 32'h0;
        wr1_en      = 1'b0;
        wr1_addr    = 5'd0;
        wr1_data    = 32'h0;
        sb_set_en   = 1'b0;
        sb_set_addr = 5'd0;
    endtask

    // Check all visible outputs against one expectation set.
    task automatic check_all(input string tag, input logic [31:0] d0, input logic [31:0] d1,
                             input logic [1:0] busy, input logic [5:0] cnt);
        check_output($sformatf("%s rd_data0", tag), rd_data[31:0], d0);
        check_output($sformatf("%s rd_data1", tag), rd_data[63:32], d1);
        check_output($sformatf("%s rd_busy", tag), {30'h0, rd_busy}, {30'h0, busy});
        check_output($sformatf("%s pend_cnt", tag), {26'h0, pend_cnt}, {26'h0, cnt});
    endtask

    initial begin
        checks   = 0;
        failures = 0;

        // Per-cycle vectors: inputs held for the cycle, expected outputs
        // sampled before that cycle's rising edge (pend_cnt is the registered
        // value from earlier edges; rd_data includes same-cycle forwarding).
        //            wr0                      wr1                      sb            ra0    ra1    d0             d1             busy   cnt
        vecs[0]  = '{1'b1, 5'd8,  32'h4,       1'b0, 5'd0,  32'h0,     1'b0, 5'd0,  5'd8,  5'd2,  32'h4,         32'h0,         2'b00, 6'd0};
        vecs[1]  = '{1'b0, 5'd0,  32'h0,       1'b0, 5'd0,  32'h0,     1'b0, 5'd0,  5'd8,  5'd2,  32'h4,         32'h0,         2'b00, 6'd0};
        vecs[2]  = '{1'b1, 5'd9,  32'h11,      1'b1, 5'd9,  32'h22,    1'b0, 5'd0,  5'd9,  5'd8,  32'h22,        32'h4,         2'b00, 6'd0};
        vecs[3]  = '{1'b0, 5'd0,  32'h0,       1'b0, 5'd0,  32'h0,     1'b0, 5'd0,  5'd9,  5'd9,  32'h22,        32'h22,        2'b00, 6'd0};
        vecs[4]  = '{1'b1, 5'd0,  32'hDEADBEEF,1'b0, 5'd0,  32'h0,     1'b1, 5'd0,  5'd0,  5'd0,  32'h0,         32'h0,         2'b00, 6'd0};
        vecs[5]  = '{1'b0, 5'd0,  32'h0,       1'b0, 5'd0,  32'h0,     1'b0, 5'd0,  5'd0,  5'd9,  32'h0,         32'h22,        2'b00, 6'd0};
        vecs[6]  = '{1'b0, 5'd0,  32'h0,       1'b0, 5'd0,  32'h0,     1'b1, 5'd5,  5'd5,  5'd9,  32'h0,         32'h22,        2'b00, 6'd0};
        vecs[7]  = '{1'b0, 5'd0,  32'h0,       1'b0, 5'd0,  32'h0,     1'b0, 5'd0,  5'd5,  5'd9,  32'h0,         32'h22,        2'b01, 6'd1};
        vecs[8]  = '{1'b0, 5'd0,  32'h0,       1'b1, 5'd5,  32'h7,     1'b0, 5'd0,  5'd5,  5'd5,  32'h7,         32'h7,         2'b00, 6'd1};
        vecs[9]  = '{1'b0, 5'd0,  32'h0,       1'b0, 5'd0,  32'h0,     1'b0, 5'd0,  5'd5,  5'd9,  32'h7,         32'h22,        2'b00, 6'd0};
        vecs[10] = '{1'b0, 5'd0,  32'h0,       1'b0, 5'd0,  32'h0,     1'b1, 5'd5,  5'd5,  5'd9,  32'h7,         32'h22,        2'b00, 6'd0};
        vecs[11] = '{1'b0, 5'd0,  32'h0,       1'b1, 5'd5,  32'h55,    1'b1, 5'd5,  5'd5,  5'd9,  32'h55,        32'h22,        2'b00, 6'd1};
        vecs[12] = '{1'b0, 5'd0,  32'h0,       1'b0, 5'd0,  32'h0,     1'b0, 5'd0,  5'd5,  5'd9,  32'h55,        32'h22,        2'b01, 6'd1};
        vecs[13] = '{1'b0, 5'd0,  32'h0,       1'b0, 5'd0,  32'h0,     1'b1, 5'd5,  5'd5,  5'd5,  32'h55,        32'h55,        2'b11, 6'd1};
        vecs[14] = '{1'b1, 5'd5,  32'h66,      1'b0, 5'd0,  32'h0,     1'b0, 5'd0,  5'd5,  5'd9,  32'h66,        32'h22,        2'b01, 6'd1};
        vecs[15] = '{1'b0, 5'd0,  32'h0,       1'b1, 5'd10, 32'hA,     1'b0, 5'd0,  5'd5,  5'd10, 32'h66,        32'hA,         2'b01, 6'd1};
        vecs[16] = '{1'b0, 5'd0,  32'h0,       1'b1, 5'd5,  32'h77,    1'b1, 5'd12, 5'd5,  5'd12, 32'h77,        32'h0,         2'b00, 6'd1};
        vecs[17] = '{1'b0, 5'd0,  32'h0,       1'b0, 5'd0,  32'h0,     1'b0, 5'd0,  5'd5,  5'd12, 32'h77,        32'h0,         2'b10, 6'd1};
        vecs[18] = '{1'b0, 5'd0,  32'h0,       1'b1, 5'd12, 32'hC,     1'b0, 5'd0,  5'd12, 5'd10, 32'hC,         32'hA,         2'b00, 6'd1};
        vecs[19] = '{1'b0, 5'd0,  32'h0,       1'b0, 5'd0,  32'h0,     1'b0, 5'd0,  5'd12, 5'd5,  32'hC,         32'h77,        2'b00, 6'd0};

        // Reset held with writes and a load issue active: outputs stay zero
        // and nothing is retained across the edges seen during reset.
        reset = 1'b1;
        set_idle();
        rd_addr = {5'd6, 5'd4};
        @(negedge clk);
        wr0_en      = 1'b1;
        wr0_addr    = 5'd4;
        wr0_data    = 32'hFF;
        wr1_en      = 1'b1;
        wr1_addr    = 5'd6;
        wr1_data    = 32'hEE;
        sb_set_en   = 1'b1;
        sb_set_addr = 5'd6;
        #2;
        check_all("reset_hold", 32'h0, 32'h0, 2'b00, 6'd0);
        @(negedge clk);
        reset = 1'b0;
        set_idle();
        #2;
        check_all("post_reset", 32'h0, 32'h0, 2'b00, 6'd0);

        for (int i = 0; i < NVEC; i++) begin
            @(negedge clk);
            apply_stimulus(vecs[i]);
            #2;
            check_all($sformatf("vec%0d", i), vecs[i].exp_d0, vecs[i].exp_d1,
                      vecs[i].exp_busy, vecs[i].exp_cnt);
        end

        // Fill: issue loads to every register including 0, which is ignored,
        // so 31 registers end up pending.
        for (int r = 0; r < 32; r++) begin
            @(negedge clk);
            set_idle();
            sb_set_en   = 1'b1;
            sb_set_addr = 5'(r);
        end
        @(negedge clk);
        set_idle();
        wr0_en   = 1'b1;
        wr0_addr = 5'd8;
        wr0_data = 32'h99;
        wr1_en   = 1'b1;
        wr1_addr = 5'd3;
        wr1_data = 32'h33;
        rd_addr  = {5'd3, 5'd8};
        #1;
        check_all("full", 32'h99, 32'h33, 2'b01, 6'd31);

        // Asynchronous reset between edges with writes still driven.
        #1;
        reset = 1'b1;
        #1;
        check_all("async_reset", 32'h0, 32'h0, 2'b00, 6'd0);

        // Release and write on the very first edge afterwards.
        @(negedge clk);
        reset    = 1'b0;
        set_idle();
        wr0_en   = 1'b1;
        wr0_addr = 5'd7;
        wr0_data = 32'h1234;
        rd_addr  = {5'd3, 5'd8};
        #2;
        check_all("release", 32'h0, 32'h0, 2'b00, 6'd0);
        @(negedge clk);
        set_idle();
        rd_addr = {5'd9, 5'd7};
        #2;
        check_all("first_write", 32'h1234, 32'h0, 2'b00, 6'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
